// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if
//   Request and response channels between the requesting datapath units and
//   the shared-multiplier arbiter.
//   req_valid  per-requester operation request
//   req_ready  one-hot grant pulse, operands accepted this cycle
//   req_a/b    packed operands, requester i at [i*DW +: DW]
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     requester index the response belongs to
//   rsp_data   normalised sign-magnitude product
//   master: requester side; slave: arbiter side.
interface mult_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*DW-1:0]       req_a;
    logic [NREQ*DW-1:0]       req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [$clog2(NREQ)-1:0]  rsp_id;
    logic [2*DW-1:0]          rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one registered sign-magnitude multiplier among NREQ requesters.
//   Round-robin grant, one operation in flight, fixed multiplier latency LAT,
//   tagged product returned on a valid/ready response channel.
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   bus    request/response channels (slave side)
//   mul_a  registered operand A to the multiplier
//   mul_b  registered operand B to the multiplier
//   mul_p  multiplier product
//   busy   high whenever the FSM is not idle
module mult_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    mult_share_arbiter_if.slave      bus,
    output logic [DW-1:0]            mul_a,
    output logic [DW-1:0]            mul_b,
    input  logic [2*DW-1:0]          mul_p,
    output logic                     busy
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     id;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic [NREQ-1:0]   req_ready_w;
    logic              load_ops;
    logic              capture;
    logic              rsp_done;
    logic              rsp_valid_q;
    logic [IW-1:0]     rsp_id_q;
    logic [2*DW-1:0]   rsp_data_q;
    logic [2*DW-1:0]   prod_norm;

    // Search starts one past the last winner so a requester that keeps
    // req_valid high queues behind everyone else.
    always_comb begin : arb
        int unsigned cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(rr_ptr) + i) % NREQ;
            if (!grant_any && bus.req_valid[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    // Negative zero from the multiplier is folded to +0.
    assign prod_norm = (mul_p[2*DW-2:0] == '0) ? '0 : mul_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        req_ready_w = '0;
        load_ops    = 1'b0;
        capture     = 1'b0;
        rsp_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    req_ready_w[grant_idx] = 1'b1;
                    load_ops               = 1'b1;
                    next_state             = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt is 0 on the first WAIT cycle, so cnt==LAT is exactly
                // LAT edges after the operands reached the multiplier.
                if (cnt == CW'(LAT)) begin
                    capture    = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done   = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rr_ptr      <= IW'(NREQ - 1);
            id          <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (load_ops) begin
                mul_a  <= bus.req_a[grant_idx*DW +: DW];
                mul_b  <= bus.req_b[grant_idx*DW +: DW];
                id     <= grant_idx;
                rr_ptr <= grant_idx;
                cnt    <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end

            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id;
                rsp_data_q  <= prod_norm;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Drives two arbiter instances (LAT=1 and LAT=3) with a behavioural
//   sign-magnitude multiplier behind each. Expected responses of the LAT=1
//   instance are queued when requests are driven and popped on handshake.
module tb_mult_share_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus1 ();
    mult_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus3 ();

    logic [DW-1:0]   mul_a1, mul_b1, mul_a3, mul_b3;
    logic [2*DW-1:0] mul_p1, mul_p3;
    logic            busy1, busy3;

    mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus1),
        .mul_a (mul_a1),
        .mul_b (mul_b1),
        .mul_p (mul_p1),
        .busy  (busy1)
    );

    mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus3),
        .mul_a (mul_a3),
        .mul_b (mul_b3),
        .mul_p (mul_p3),
        .busy  (busy3)
    );

    // Reference arithmetic: raw multiplier output (may be -0) and normalised result.
    function automatic logic [15:0] smul_raw(input logic [7:0] a, input logic [7:0] b);
        logic [13:0] m;
        m = 14'(a[6:0]) * 14'(b[6:0]);
        return {a[7] ^ b[7], 1'b0, m};
    endfunction

    function automatic logic [15:0] norm_ref(input logic [15:0] p);
        return (p[14:0] == 15'd0) ? 16'h0000 : p;
    endfunction

    // Behavioural multipliers with 1 and 3 register stages.
    logic [15:0] p1_q;
    logic [15:0] p3_q [3];
    always @(posedge clk) begin
        p1_q    <= smul_raw(mul_a1, mul_b1);
        p3_q[0] <= smul_raw(mul_a3, mul_b3);
        p3_q[1] <= p3_q[0];
        p3_q[2] <= p3_q[1];
    end
    assign mul_p1 = p1_q;
    assign mul_p3 = p3_q[2];

    logic [1:0]  exp_id_q   [$];
    logic [15:0] exp_data_q [$];
    logic [7:0]  a_arr [NREQ];
    logic [7:0]  b_arr [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response scoreboard for the LAT=1 instance.
    always @(negedge clk) begin
        if (!rst && bus1.rsp_valid && bus1.rsp_ready) begin
            if (exp_data_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus1.rsp_valid), 32'd0);
            end else begin
                logic [1:0]  e_id;
                logic [15:0] e_data;
                e_id   = exp_id_q.pop_front();
                e_data = exp_data_q.pop_front();
                check("rsp_id", 32'(bus1.rsp_id), 32'(e_id));
                check("rsp_data", 32'(bus1.rsp_data), 32'(e_data));
            end
        end
    end

    task automatic set_ops(input int sel);
        for (int i = 0; i < int'(NREQ); i++) begin
            if (sel == 0) begin
                bus1.req_a[i*DW +: DW] = a_arr[i];
                bus1.req_b[i*DW +: DW] = b_arr[i];
            end else begin
                bus3.req_a[i*DW +: DW] = a_arr[i];
                bus3.req_b[i*DW +: DW] = b_arr[i];
            end
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns one cycle after the grant.
    task automatic issue_one(input int sel, input int r, input logic push,
                             input logic [7:0] a, input logic [7:0] b);
        a_arr[r] = a;
        b_arr[r] = b;
        set_ops(sel);
        if (push) begin
            exp_id_q.push_back(2'(r));
            exp_data_q.push_back(norm_ref(smul_raw(a, b)));
        end
        if (sel == 0) bus1.req_valid = 4'(1 << r);
        else          bus3.req_valid = 4'(1 << r);
        @(negedge clk);
        check("grant", 32'((sel == 0) ? bus1.req_ready : bus3.req_ready), 32'(1 << r));
        @(posedge clk); #1;
        bus1.req_valid = '0;
        bus3.req_valid = '0;
    endtask

    // n counts cycles from the grant cycle to the first cycle with rsp_valid.
    task automatic wait_valid(input int sel, output int n);
        logic hit;
        hit = 1'b0;
        n   = 0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk);
            if ((sel == 0) ? bus1.rsp_valid : bus3.rsp_valid) begin
                n   = w;
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!hit) check("rsp_timeout", 32'(hit), 32'd1);
    endtask

    task automatic drain();
        for (int w = 0; w < 40; w++) begin
            @(posedge clk); #1;
            if (exp_data_q.size() == 0) break;
        end
        check("drain", 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n;
        int last;
        int order [5];
        logic found;

        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < int'(NREQ); i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b1;
        bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus1.rsp_id), 32'd0);
        check("rst_rsp_data", 32'(bus1.rsp_data), 32'd0);
        check("rst_mul_a", 32'(mul_a1), 32'd0);
        check("rst_mul_b", 32'(mul_b1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_req_ready", 32'(bus1.req_ready), 32'd0);
        check("rst_busy_lat3", 32'(busy3), 32'd0);
        @(posedge clk); #1;

        // Single request from req0: 3 * -5 = -15
        issue_one(0, 0, 1'b1, 8'h03, 8'h85);
        wait_valid(0, n);
        check("t1_latency", 32'(n), 32'd3);
        check("t1_busy", 32'(busy1), 32'd1);
        check("t1_id", 32'(bus1.rsp_id), 32'd0);
        check("t1_data", 32'(bus1.rsp_data), 32'h800F);
        drain();

        // All requesters held valid from reset: rotation 0,1,2,3,0, one grant per 4 cycles
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_arr[0] = 8'h03; b_arr[0] = 8'h02;
        a_arr[1] = 8'h84; b_arr[1] = 8'h02;
        a_arr[2] = 8'h05; b_arr[2] = 8'h83;
        a_arr[3] = 8'h86; b_arr[3] = 8'h83;
        set_ops(0);
        for (int k = 0; k < 5; k++) begin
            exp_id_q.push_back(2'(order[k]));
            exp_data_q.push_back(norm_ref(smul_raw(a_arr[order[k]], b_arr[order[k]])));
        end
        bus1.req_valid = 4'hF;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (bus1.req_ready != '0) begin
                    found = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("t2_found", 32'(found), 32'd1);
            check("t2_grant", 32'(bus1.req_ready), 32'(1 << order[k]));
            if (k > 0) check("t2_gap", 32'(int'(cyc) - last), 32'd4);
            last = int'(cyc);
            @(posedge clk); #1;
        end
        bus1.req_valid = '0;
        drain();

        // Negative zero: -0 * 5 must come back as +0
        issue_one(0, 3, 1'b1, 8'h80, 8'h05);
        wait_valid(0, n);
        check("t4_latency", 32'(n), 32'd3);
        check("t4_data", 32'(bus1.rsp_data), 32'h0000);
        drain();

        // Response back-pressure: -10 * 12 = -120 held across a 5-cycle stall
        bus1.rsp_ready = 1'b0;
        issue_one(0, 1, 1'b1, 8'h8A, 8'h0C);
        wait_valid(0, n);
        check("t3_latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) bus1.req_valid = 4'hF;
            @(negedge clk);
            check("t3_hold_valid", 32'(bus1.rsp_valid), 32'd1);
            check("t3_hold_id", 32'(bus1.rsp_id), 32'd1);
            check("t3_hold_data", 32'(bus1.rsp_data), 32'h8078);
            check("t3_no_grant", 32'(bus1.req_ready), 32'd0);
            check("t3_busy", 32'(busy1), 32'd1);
        end
        @(posedge clk); #1;
        bus1.req_valid = '0;
        bus1.rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        check("t3_released", 32'(bus1.rsp_valid), 32'd0);
        check("t3_idle", 32'(busy1), 32'd0);
        @(posedge clk); #1;

        // Reset while an operation is in WAIT: it must vanish
        issue_one(0, 2, 1'b0, 8'h11, 8'h22);
        check("t5_mul_a_loaded", 32'(mul_a1), 32'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("t5_rsp_id", 32'(bus1.rsp_id), 32'd0);
        check("t5_rsp_data", 32'(bus1.rsp_data), 32'd0);
        check("t5_mul_a", 32'(mul_a1), 32'd0);
        check("t5_mul_b", 32'(mul_b1), 32'd0);
        check("t5_busy", 32'(busy1), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("t5_no_rsp", 32'(bus1.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        exp_id_q.push_back(2'd0);
        exp_data_q.push_back(norm_ref(smul_raw(a_arr[0], b_arr[0])));
        bus1.req_valid = 4'hF;
        @(negedge clk);
        check("t5_grant_after_rst", 32'(bus1.req_ready), 32'd1);
        @(posedge clk); #1;
        bus1.req_valid = '0;
        wait_valid(0, n);
        check("t5_latency", 32'(n), 32'd3);
        drain();

        // LAT=3 instance: req2, 7 * 6 = 42
        issue_one(1, 2, 1'b0, 8'h07, 8'h06);
        wait_valid(1, n);
        check("t6_latency", 32'(n), 32'd5);
        check("t6_id", 32'(bus3.rsp_id), 32'd2);
        check("t6_data", 32'(bus3.rsp_data), 32'h002A);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_released", 32'(bus3.rsp_valid), 32'd0);
        check("t6_idle", 32'(busy3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
